fifo_read_stream: RTL and testbench

//   Read-side drain engine for async_fifo, in the read_clk domain.

---
 rtl/fifo_read_stream.sv | 125 ++++++++++++
 tb/tb_fifo_read_stream.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: read-side drain engine for an async FIFO.
// Pops words from the FIFO read port and re-presents them as a valid/ready
// stream through a 3-entry prefetch buffer. Pop decisions depend only on
// registered occupancy, so there is no combinational m_ready -> p_read_en path.
module fifo_read_stream #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                read_clk,
    input  logic                read_rst_n,
    input  logic                enable,
    output logic                p_read_en,
    input  logic [BITS-1:0]     p_read_data,
    input  logic                p_read_empty,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS-1:0]     m_data,
    output logic [CNT_BITS-1:0] pop_count
);

    localparam int DEPTH = 3;

    // Buffer bookkeeping: occupancy, outstanding pop, circular pointers.
    logic [1:0]          r_occ;
    logic                r_inflight;
    logic [1:0]          r_rd_ptr;
    logic [1:0]          r_wr_ptr;
    logic [CNT_BITS-1:0] r_pop_count;

    // Slot contents, gathered into one packed vector for the output mux.
    logic [DEPTH-1:0][BITS-1:0] w_slots;

    logic       w_arrival;
    logic       w_consume;
    logic       w_room;
    logic [2:0] w_reserved;
    logic [2:0] w_occ_sum;
    logic [1:0] w_occ_next;
    logic [1:0] w_rd_ptr_next;
    logic [1:0] w_wr_ptr_next;

    // Advance a buffer pointer, wrapping after the last slot.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A word lands one cycle after its pop; a word leaves on handshake.
    assign w_arrival = r_inflight;
    assign w_consume = m_valid & m_ready;

    // Slots already held plus the one reserved by an outstanding pop.
    assign w_reserved = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_room     = (w_reserved < 3'(DEPTH));

    // Pop only when a slot is guaranteed to be free on arrival.
    assign p_read_en = read_rst_n & enable & ~p_read_empty & w_room;

    // Occupancy after this cycle's arrival and consume.
    assign w_occ_sum  = w_reserved - {2'b00, w_consume};
    assign w_occ_next = w_occ_sum[1:0];

    assign w_rd_ptr_next = w_consume ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_wr_ptr_next = w_arrival ? ptr_inc(r_wr_ptr) : r_wr_ptr;

    assign m_valid   = (r_occ != 2'd0);
    assign pop_count = r_pop_count;

    // Head-of-buffer mux; stream data always comes from a register.
    always_comb begin
        m_data = '0;
        case (r_rd_ptr)
            2'd0:    m_data = w_slots[0];
            2'd1:    m_data = w_slots[1];
            2'd2:    m_data = w_slots[2];
            default: m_data = '0;
        endcase
    end

    // One storage register per slot, written when the arriving word targets it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [BITS-1:0] r_slot;

            // Capture the arriving FIFO word into this slot.
            always_ff @(posedge read_clk or negedge read_rst_n) begin
                if (!read_rst_n) begin
                    r_slot <= '0;
                end else if (w_arrival && (r_wr_ptr == 2'(gi))) begin
                    r_slot <= p_read_data;
                end
            end

            assign w_slots[gi] = r_slot;
        end
    endgenerate

    // Occupancy, pointers and the outstanding-pop flag.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 2'd0;
            r_wr_ptr   <= 2'd0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= p_read_en;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ptr   <= w_wr_ptr_next;
        end
    end

    // Count pops at issue time; wraps naturally at the counter width.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_pop_count <= '0;
        end else if (p_read_en) begin
            r_pop_count <= r_pop_count + 1'b1;
        end
    end

    // Slot reservation must keep occupancy inside 0..3; underflow wraps to 7.
    a_occ_range: assert property (@(posedge read_clk) disable iff (!read_rst_n)
        (w_occ_sum <= 3'(DEPTH)));

endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream: per-cycle vector table plus sequences
// for streaming, back-pressure drain and reset with a full buffer.
module tb_fifo_read_stream;

    localparam int BITS = 32;

    logic             read_clk = 1'b0;
    logic             read_rst_n;
    logic             enable;
    logic             m_ready;
    logic             p_read_en;
    logic [BITS-1:0]  p_read_data;
    logic             p_read_empty;
    logic             m_valid;
    logic [BITS-1:0]  m_data;
    logic [15:0]      pop_count;

    logic             p_read_en4;
    logic             m_valid4;
    logic [BITS-1:0]  m_data4;
    logic [3:0]       pop_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 read_clk = ~read_clk;

    fifo_read_stream #(.BITS(BITS), .CNT_BITS(16)) dut (
        .read_clk    (read_clk),
        .read_rst_n  (read_rst_n),
        .enable      (enable),
        .p_read_en   (p_read_en),
        .p_read_data (p_read_data),
        .p_read_empty(p_read_empty),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .pop_count   (pop_count)
    );

    // Second instance with a narrow counter, fed identically, to see wrap.
    fifo_read_stream #(.BITS(BITS), .CNT_BITS(4)) dut4 (
        .read_clk    (read_clk),
        .read_rst_n  (read_rst_n),
        .enable      (enable),
        .p_read_en   (p_read_en4),
        .p_read_data (p_read_data),
        .p_read_empty(p_read_empty),
        .m_valid     (m_valid4),
        .m_ready     (m_ready),
        .m_data      (m_data4),
        .pop_count   (pop_count4)
    );

    // FIFO model: bench pushes into fmem, DUT pops with one cycle of read latency.
    logic [BITS-1:0] fmem [0:255];
    int wr_idx = 0;
    int rd_idx;
    assign p_read_empty = (rd_idx == wr_idx);

    always @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            rd_idx <= 0;
        end else if (p_read_en) begin
            p_read_data <= fmem[rd_idx[7:0]];
            rd_idx      <= rd_idx + 1;
        end
    end

    task automatic push(input logic [BITS-1:0] v);
        fmem[wr_idx[7:0]] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream scoreboard: every handshake must deliver the next pushed word.
    int deliv_idx = 0;
    always begin
        @(negedge read_clk);
        #4;
        if (!read_rst_n) begin
            deliv_idx = 0;
        end else if (m_valid && m_ready) begin
            $display("deliver #%0d data=%h", deliv_idx, m_data);
            check($sformatf("stream_data[%0d]", deliv_idx), m_data, fmem[deliv_idx[7:0]]);
            deliv_idx = deliv_idx + 1;
        end
    end

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        rdy;
        logic        pen;
        logic        mv;
        logic        chk_md;
        logic [31:0] md;
        logic [15:0] pc;
    } row_t;

    row_t rows [0:47];
    int   n_rows = 0;

    task automatic add(input logic rst_n, input logic en, input logic rdy,
                       input logic pen, input logic mv, input logic chk_md,
                       input logic [31:0] md, input logic [15:0] pc);
        rows[n_rows].rst_n  = rst_n;
        rows[n_rows].en     = en;
        rows[n_rows].rdy    = rdy;
        rows[n_rows].pen    = pen;
        rows[n_rows].mv     = mv;
        rows[n_rows].chk_md = chk_md;
        rows[n_rows].md     = md;
        rows[n_rows].pc     = pc;
        n_rows++;
    endtask

    // Inputs change at the falling edge; outputs checked 2 time units later.
    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge read_clk);
            read_rst_n = rows[i].rst_n;
            enable     = rows[i].en;
            m_ready    = rows[i].rdy;
            #2;
            $display("row %0d: pen=%0b mv=%0b md=%h pc=%0d", i, p_read_en, m_valid, m_data, pop_count);
            check($sformatf("row%0d_pen", i), 32'(p_read_en), 32'(rows[i].pen));
            check($sformatf("row%0d_mv", i), 32'(m_valid), 32'(rows[i].mv));
            check($sformatf("row%0d_pc", i), 32'(pop_count), 32'(rows[i].pc));
            check($sformatf("row%0d_pc4", i), 32'(pop_count4), 32'(rows[i].pc[3:0]));
            if (rows[i].chk_md)
                check($sformatf("row%0d_md", i), m_data, rows[i].md);
        end
    endtask

    task automatic do_reset();
        @(negedge read_clk);
        read_rst_n = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        wr_idx     = 0;
        repeat (2) @(negedge read_clk);
        read_rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input string name, input int target, input int budget);
        int k = 0;
        while (deliv_idx < target && k < budget) begin
            @(negedge read_clk);
            #2;
            k++;
        end
        check(name, 32'(deliv_idx), 32'(target));
    endtask

    int t12_lo, t12_hi, t4_lo, t4_hi, t5_lo, t5_hi;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold then single word A5A5_0001 (rst_n en rdy | pen mv chk md pc).
        t12_lo = n_rows;
        add(0, 1, 1,  0, 0, 1, 32'h0,          0);
        add(0, 1, 1,  0, 0, 1, 32'h0,          0);
        add(0, 1, 1,  0, 0, 1, 32'h0,          0);
        add(1, 1, 1,  1, 0, 1, 32'h0,          0);
        add(1, 1, 1,  0, 0, 1, 32'h0,          1);
        add(1, 1, 1,  0, 1, 1, 32'hA5A5_0001,  1);
        add(1, 1, 1,  0, 0, 1, 32'h0,          1);
        t12_hi = n_rows;
        // Back-pressure: 10 words 0..9, m_ready low then released.
        t4_lo = n_rows;
        add(1, 1, 0,  1, 0, 0, 32'h0,          0);
        add(1, 1, 0,  1, 0, 0, 32'h0,          1);
        add(1, 1, 0,  1, 1, 1, 32'h0,          2);
        add(1, 1, 0,  0, 1, 1, 32'h0,          3);
        add(1, 1, 0,  0, 1, 1, 32'h0,          3);
        add(1, 1, 0,  0, 1, 1, 32'h0,          3);
        add(1, 1, 1,  0, 1, 1, 32'h0,          3);
        add(1, 1, 1,  1, 1, 1, 32'h1,          3);
        add(1, 1, 1,  1, 1, 1, 32'h2,          4);
        t4_hi = n_rows;
        // enable dropped after word 4 popped, then restored.
        t5_lo = n_rows;
        add(1, 1, 1,  1, 0, 0, 32'h0,          0);
        add(1, 1, 1,  1, 0, 0, 32'h0,          1);
        add(1, 1, 1,  1, 1, 1, 32'h500,        2);
        add(1, 1, 1,  1, 1, 1, 32'h501,        3);
        add(1, 1, 1,  1, 1, 1, 32'h502,        4);
        add(1, 0, 1,  0, 1, 1, 32'h503,        5);
        add(1, 0, 1,  0, 1, 1, 32'h504,        5);
        add(1, 0, 1,  0, 0, 0, 32'h0,          5);
        add(1, 0, 1,  0, 0, 0, 32'h0,          5);
        add(1, 1, 1,  1, 0, 0, 32'h0,          5);
        add(1, 1, 1,  1, 0, 0, 32'h0,          6);
        add(1, 1, 1,  1, 1, 1, 32'h505,        7);
        t5_hi = n_rows;

        read_rst_n = 1'b1;
        enable     = 1'b0;
        m_ready    = 1'b0;
        #1;
        read_rst_n = 1'b0;
        push(32'hA5A5_0001);

        // Reset behaviour and single-word latency.
        apply_rows(t12_lo, t12_hi);
        check("single_deliv", 32'(deliv_idx), 32'd1);

        // Streaming 16 words back to back.
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(i));
        begin
            int k = 0;
            @(negedge read_clk);
            enable  = 1'b1;
            m_ready = 1'b1;
            #2;
            while (!m_valid && k < 8) begin
                @(negedge read_clk);
                #2;
                k++;
            end
            check("stream_start", 32'(m_valid), 32'd1);
            for (int i = 0; i < 16; i++) begin
                check($sformatf("stream_valid[%0d]", i), 32'(m_valid), 32'd1);
                @(negedge read_clk);
                #2;
            end
            check("stream_end_valid", 32'(m_valid), 32'd0);
            check("stream_pop_count", 32'(pop_count), 32'd16);
            check("stream_pop_count4", 32'(pop_count4), 32'd0);
            check("stream_deliv", 32'(deliv_idx), 32'd16);
        end

        // Back-pressure with 10 queued words.
        do_reset();
        for (int i = 0; i < 10; i++) push(32'(i));
        apply_rows(t4_lo, t4_hi);
        wait_deliv("bp_deliv", 10, 40);
        check("bp_pop_count", 32'(pop_count), 32'd10);
        @(negedge read_clk);
        #2;
        check("bp_end_valid", 32'(m_valid), 32'd0);

        // enable gap mid-stream.
        do_reset();
        for (int i = 0; i < 10; i++) push(32'h500 + 32'(i));
        apply_rows(t5_lo, t5_hi);
        wait_deliv("en_deliv", 10, 40);
        check("en_pop_count", 32'(pop_count), 32'd10);

        // Reset with a full buffer, then counter wrap on the narrow instance.
        do_reset();
        for (int i = 0; i < 20; i++) push(32'h6000 + 32'(i));
        @(negedge read_clk);
        enable  = 1'b1;
        m_ready = 1'b0;
        repeat (6) @(negedge read_clk);
        #2;
        check("full_valid", 32'(m_valid), 32'd1);
        check("full_pop_count", 32'(pop_count), 32'd3);
        check("full_pen", 32'(p_read_en), 32'd0);
        #1;
        read_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_pen", 32'(p_read_en), 32'd0);
        check("rst_mid_pc", 32'(pop_count), 32'd0);
        check("rst_mid_md", m_data, 32'd0);
        wr_idx = 0;
        repeat (2) @(negedge read_clk);
        for (int i = 0; i < 17; i++) push(32'h7000 + 32'(i));
        read_rst_n = 1'b1;
        m_ready    = 1'b1;
        wait_deliv("wrap_deliv", 17, 60);
        check("wrap_pop_count", 32'(pop_count), 32'd17);
        check("wrap_pop_count4", 32'(pop_count4), 32'd1);
        @(negedge read_clk);
        #2;
        check("wrap_end_valid", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
